// File: rtl/board_turn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : board_turn_ctrl
//  Brief    : Turn sequencer for the 8x8 board game. Owns the cursor and the
//             cell-ownership matrix, claims cells on select, passes the turn
//             when the per-turn timer expires and ends the game at 64 moves.
//  Revision : 1.0 - initial release
// ============================================================================
module board_turn_ctrl #(
  parameter int TURN_CYCLES = 250_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_sel,
  output logic [2:0]            pos_x,
  output logic [2:0]            pos_y,
  output logic [7:0][7:0][3:0]  mJ,
  output logic                  player,
  output logic [6:0]            move_count,
  output logic                  timeout,
  output logic                  game_over
);

  localparam int             TIMER_W    = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TURN_CYCLES - 1);

  // Button vector bit positions, highest bit is highest priority.
  localparam int B_SEL   = 4;
  localparam int B_UP    = 3;
  localparam int B_DOWN  = 2;
  localparam int B_LEFT  = 1;
  localparam int B_RIGHT = 0;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_PLACE  = 2'd1,
    S_SWITCH = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           btn_prev_q, btn_prev_d;
  logic [2:0]           pos_x_q, pos_x_d;
  logic [2:0]           pos_y_q, pos_y_d;
  logic [7:0][7:0][3:0] mj_q, mj_d;
  logic                 player_q, player_d;
  logic [6:0]           move_count_q, move_count_d;
  logic                 timeout_q, timeout_d;
  logic                 game_over_q, game_over_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;

  logic [4:0]           btn_vec_w;
  logic [4:0]           btn_edge_w;
  logic                 cell_empty_w;

  assign btn_vec_w    = {btn_sel, btn_up, btn_down, btn_left, btn_right};
  assign btn_edge_w   = btn_vec_w & ~btn_prev_q;
  assign cell_empty_w = (mj_q[pos_y_q][pos_x_q] == 4'd0);

  // Next-state and output computation for the turn FSM.
  always_comb begin
    state_d      = state_q;
    btn_prev_d   = btn_vec_w;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    mj_d         = mj_q;
    player_d     = player_q;
    move_count_d = move_count_q;
    timeout_d    = 1'b0;
    game_over_d  = game_over_q;
    timer_d      = timer_q;

    case (state_q)
      S_WAIT: begin
        if (btn_edge_w[B_SEL] && cell_empty_w) begin
          // Starting a placement outranks a timer expiry in the same cycle.
          state_d = S_PLACE;
        end else begin
          if (timer_q == TIMER_LAST) begin
            timeout_d = 1'b1;
            player_d  = ~player_q;
            timer_d   = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
          // A select on an occupied cell still consumes the cycle's action slot.
          if (!btn_edge_w[B_SEL]) begin
            if (btn_edge_w[B_UP]) begin
              if (pos_y_q != 3'd0) pos_y_d = pos_y_q - 3'd1;
            end else if (btn_edge_w[B_DOWN]) begin
              if (pos_y_q != 3'd7) pos_y_d = pos_y_q + 3'd1;
            end else if (btn_edge_w[B_LEFT]) begin
              if (pos_x_q != 3'd0) pos_x_d = pos_x_q - 3'd1;
            end else if (btn_edge_w[B_RIGHT]) begin
              if (pos_x_q != 3'd7) pos_x_d = pos_x_q + 3'd1;
            end
          end
        end
      end
      S_PLACE: begin
        mj_d[pos_y_q][pos_x_q] = player_q ? 4'd2 : 4'd1;
        state_d                = S_SWITCH;
      end
      S_SWITCH: begin
        move_count_d = move_count_q + 7'd1;
        player_d     = ~player_q;
        timer_d      = '0;
        if (move_count_q == 7'd63) begin
          game_over_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_WAIT;
      btn_prev_q   <= '0;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      mj_q         <= '0;
      player_q     <= 1'b0;
      move_count_q <= '0;
      timeout_q    <= 1'b0;
      game_over_q  <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      btn_prev_q   <= btn_prev_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      mj_q         <= mj_d;
      player_q     <= player_d;
      move_count_q <= move_count_d;
      timeout_q    <= timeout_d;
      game_over_q  <= game_over_d;
      timer_q      <= timer_d;
    end
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign mJ         = mj_q;
  assign player     = player_q;
  assign move_count = move_count_q;
  assign timeout    = timeout_q;
  assign game_over  = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_board_turn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_board_turn_ctrl
//  Brief    : Self-checking bench for board_turn_ctrl. One instance with a long
//             turn for cursor/placement/fill tests, one with a 16-cycle turn
//             for timer expiry tests.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_board_turn_ctrl;

  localparam logic [4:0] B_SEL = 5'b10000;
  localparam logic [4:0] B_UP  = 5'b01000;
  localparam logic [4:0] B_DN  = 5'b00100;
  localparam logic [4:0] B_LT  = 5'b00010;
  localparam logic [4:0] B_RT  = 5'b00001;

  typedef struct {
    logic [4:0] btn;
    logic [2:0] ex;
    logic [2:0] ey;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] btn_a, btn_t;

  logic [2:0]           pos_x_a, pos_y_a, pos_x_t, pos_y_t;
  logic [7:0][7:0][3:0] mj_a, mj_t, exp_mj;
  logic                 player_a, player_t, to_a, to_t, go_a, go_t;
  logic [6:0]           cnt_a, cnt_t;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  board_turn_ctrl #(.TURN_CYCLES(1000)) dut_a (
    .clk(clk), .rst(rst),
    .btn_up(btn_a[3]), .btn_down(btn_a[2]), .btn_left(btn_a[1]),
    .btn_right(btn_a[0]), .btn_sel(btn_a[4]),
    .pos_x(pos_x_a), .pos_y(pos_y_a), .mJ(mj_a), .player(player_a),
    .move_count(cnt_a), .timeout(to_a), .game_over(go_a)
  );

  board_turn_ctrl #(.TURN_CYCLES(16)) dut_t (
    .clk(clk), .rst(rst),
    .btn_up(btn_t[3]), .btn_down(btn_t[2]), .btn_left(btn_t[1]),
    .btn_right(btn_t[0]), .btn_sel(btn_t[4]),
    .pos_x(pos_x_t), .pos_y(pos_y_t), .mJ(mj_t), .player(player_t),
    .move_count(cnt_t), .timeout(to_t), .game_over(go_t)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int mj_diff(input logic [7:0][7:0][3:0] a, input logic [7:0][7:0][3:0] b);
    int n = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        if (a[y][x] !== b[y][x]) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    btn_a = '0;
    btn_t = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_a(input logic [4:0] b);
    btn_a = b;
    tick();
    btn_a = '0;
    tick();
  endtask

  task automatic sel_a();
    btn_a = B_SEL;
    tick();
    btn_a = '0;
    tick();
    tick();
  endtask

  // Bounds the whole run in case the clock or a task ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   k;
    logic [2:0] x;

    // Cursor vectors starting from (0,0) after reset.
    vecs.push_back('{B_RT, 3'd1, 3'd0});
    vecs.push_back('{B_RT, 3'd2, 3'd0});
    vecs.push_back('{B_RT, 3'd3, 3'd0});
    vecs.push_back('{B_DN, 3'd3, 3'd1});
    vecs.push_back('{B_DN, 3'd3, 3'd2});
    vecs.push_back('{B_LT, 3'd2, 3'd2});
    vecs.push_back('{B_LT, 3'd1, 3'd2});
    vecs.push_back('{B_LT, 3'd0, 3'd2});
    vecs.push_back('{B_UP, 3'd0, 3'd1});
    vecs.push_back('{B_UP, 3'd0, 3'd0});
    vecs.push_back('{B_LT, 3'd0, 3'd0});
    vecs.push_back('{B_UP, 3'd0, 3'd0});
    for (int i = 1; i <= 9; i++)
      vecs.push_back('{B_RT, (i > 7) ? 3'd7 : 3'(i), 3'd0});
    for (int i = 1; i <= 9; i++)
      vecs.push_back('{B_DN, 3'd7, (i > 7) ? 3'd7 : 3'(i)});
    vecs.push_back('{B_UP | B_DN, 3'd7, 3'd6});
    vecs.push_back('{B_LT | B_RT, 3'd6, 3'd6});
    vecs.push_back('{B_DN | B_RT, 3'd6, 3'd7});

    // ---------------- reset values ----------------
    do_reset();
    chk("rst_pos_x", pos_x_a, 0);
    chk("rst_pos_y", pos_y_a, 0);
    chk("rst_player", player_a, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_timeout", to_a, 0);
    chk("rst_game_over", go_a, 0);
    chk("rst_mj_zero", mj_diff(mj_a, '0), 0);

    // ---------------- cursor table ----------------
    foreach (vecs[i]) begin
      btn_a = vecs[i].btn;
      tick();
      chk($sformatf("vec%0d_x", i), pos_x_a, vecs[i].ex);
      chk($sformatf("vec%0d_y", i), pos_y_a, vecs[i].ey);
      btn_a = '0;
      tick();
    end
    chk("moves_mj_zero", mj_diff(mj_a, '0), 0);
    chk("moves_count", cnt_a, 0);

    // ---------------- placement latency ----------------
    do_reset();
    repeat (3) pulse_a(B_RT);
    repeat (2) pulse_a(B_DN);
    btn_a = B_SEL;
    tick();
    chk("sel_n1_mj", mj_a[2][3], 0);
    btn_a = '0;
    tick();
    chk("sel_n2_mj", mj_a[2][3], 1);
    chk("sel_n2_player", player_a, 0);
    chk("sel_n2_count", cnt_a, 0);
    tick();
    chk("sel_n3_player", player_a, 1);
    chk("sel_n3_count", cnt_a, 1);

    // Select on occupied cell is ignored.
    sel_a();
    tick();
    chk("occ_mj", mj_a[2][3], 1);
    chk("occ_player", player_a, 1);
    chk("occ_count", cnt_a, 1);

    // Same-cycle select and right: place at old x, cursor stays.
    pulse_a(B_RT);
    btn_a = B_SEL | B_RT;
    tick();
    btn_a = '0;
    tick();
    tick();
    chk("selrt_x", pos_x_a, 4);
    chk("selrt_mj", mj_a[2][4], 2);
    chk("selrt_player", player_a, 0);
    chk("selrt_count", cnt_a, 2);

    // Held select yields a single placement.
    pulse_a(B_RT);
    btn_a = B_SEL;
    repeat (10) tick();
    btn_a = '0;
    tick();
    tick();
    chk("held_count", cnt_a, 3);
    chk("held_mj", mj_a[2][5], 1);
    chk("held_player", player_a, 1);

    // Reset in the middle of a placement discards it.
    pulse_a(B_RT);
    btn_a = B_SEL;
    tick();
    rst   = 1'b1;
    btn_a = '0;
    tick();
    rst = 1'b0;
    chk("rstplace_mj", mj_a[2][6], 0);
    chk("rstplace_mj_all", mj_diff(mj_a, '0), 0);
    chk("rstplace_count", cnt_a, 0);
    chk("rstplace_x", pos_x_a, 0);

    // ---------------- turn timer (16 cycles) ----------------
    do_reset();
    repeat (15) tick();
    chk("tmr_e15_to", to_t, 0);
    chk("tmr_e15_player", player_t, 0);
    tick();
    chk("tmr_e16_to", to_t, 1);
    chk("tmr_e16_player", player_t, 1);
    tick();
    chk("tmr_e17_to", to_t, 0);
    repeat (14) tick();
    chk("tmr_e31_to", to_t, 0);
    chk("tmr_e31_player", player_t, 1);
    btn_t = B_SEL;
    tick();
    chk("tmr_selexp_to", to_t, 0);
    chk("tmr_selexp_player", player_t, 1);
    btn_t = '0;
    tick();
    chk("tmr_selexp_mj", mj_t[0][0], 2);
    tick();
    chk("tmr_selexp_switch_player", player_t, 0);
    chk("tmr_selexp_count", cnt_t, 1);
    repeat (15) tick();
    chk("tmr_newturn_e15_to", to_t, 0);
    tick();
    chk("tmr_newturn_e16_to", to_t, 1);
    chk("tmr_newturn_player", player_t, 1);

    // ---------------- fill the board ----------------
    do_reset();
    exp_mj = '0;
    k      = 0;
    for (int y = 0; y < 8; y++) begin
      for (int j = 0; j < 8; j++) begin
        x = (y % 2 == 0) ? 3'(j) : 3'(7 - j);
        if (k == 63) begin
          chk("fill63_count", cnt_a, 63);
          chk("fill63_game_over", go_a, 0);
        end
        sel_a();
        exp_mj[y][x] = (k % 2 == 0) ? 4'd1 : 4'd2;
        k++;
        if (j < 7) pulse_a((y % 2 == 0) ? B_RT : B_LT);
      end
      if (y < 7) pulse_a(B_DN);
    end
    chk("fill_count", cnt_a, 64);
    chk("fill_game_over", go_a, 1);
    chk("fill_player", player_a, 0);
    chk("fill_mj", mj_diff(mj_a, exp_mj), 0);

    // Buttons are ignored once the game is over.
    pulse_a(B_RT);
    pulse_a(B_UP);
    sel_a();
    repeat (20) tick();
    chk("done_x", pos_x_a, 0);
    chk("done_y", pos_y_a, 7);
    chk("done_count", cnt_a, 64);
    chk("done_game_over", go_a, 1);
    chk("done_mj", mj_diff(mj_a, exp_mj), 0);
    chk("done_timeout", to_a, 0);

    // Reset out of DONE.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstdone_game_over", go_a, 0);
    chk("rstdone_count", cnt_a, 0);
    chk("rstdone_player", player_a, 0);
    chk("rstdone_y", pos_y_a, 0);
    chk("rstdone_mj", mj_diff(mj_a, '0), 0);
    pulse_a(B_DN);
    chk("rstdone_alive_y", pos_y_a, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
